// File: rtl/regfile_writeback_queue.sv
// Write-back queue for the 8x8 register file: merges MEM and ALU results and retires one per cycle.
// Optional forwarding lookup port is built when WBQ_FORWARD_EN is defined.
module regfile_writeback_queue #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mem_valid,
   input  logic [ADDR_W-1:0]        mem_addr,
   input  logic [DATA_W-1:0]        mem_data,
   output logic                     mem_ready,
   input  logic                     alu_valid,
   input  logic [ADDR_W-1:0]        alu_addr,
   input  logic [DATA_W-1:0]        alu_data,
   output logic                     alu_ready,
   output logic                     reg_write,
   output logic [ADDR_W-1:0]        addr_write,
   output logic [DATA_W-1:0]        write_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
`ifdef WBQ_FORWARD_EN
   ,
   input  logic [ADDR_W-1:0]        lookup_addr,
   output logic                     fwd_hit,
   output logic [DATA_W-1:0]        fwd_data
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Handshake: a producer's result is taken at the rising edge when its valid
   // and ready are both high; MEM wins when both present, ALU must hold.
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count_q;

   logic              mem_hs;
   logic              alu_hs;
   logic              push_acc;
   logic              push_en;
   logic              pop_en;
   logic [ADDR_W-1:0] push_addr;
   logic [DATA_W-1:0] push_data;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign mem_ready = !rst && !full;
   assign alu_ready = !rst && !full && !mem_valid;

   assign mem_hs    = mem_valid && mem_ready;
   assign alu_hs    = alu_valid && alu_ready;
   assign push_acc  = mem_hs || alu_hs;

   always_comb begin
      push_addr = alu_addr;
      push_data = alu_data;
      if (mem_hs) begin
         push_addr = mem_addr;
         push_data = mem_data;
      end
   end

   // Writes to register 0 complete the handshake but are dropped here.
   assign push_en = push_acc && (push_addr != '0);
   assign pop_en  = (count_q != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_en, pop_en})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: only slots inside the count window are ever read.
   always_ff @(posedge clk) begin
      if (!rst && push_en) begin
         addr_q[wr_ptr] <= push_addr;
         data_q[wr_ptr] <= push_data;
      end
   end

   assign count      = count_q;
   assign reg_write  = pop_en;
   assign addr_write = pop_en ? addr_q[rd_ptr] : '0;
   assign write_data = pop_en ? data_q[rd_ptr] : '0;

`ifdef WBQ_FORWARD_EN
   // Oldest-to-youngest scan so the last match left standing is the youngest.
   always_comb begin
      logic [PTR_W-1:0] idx;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (lookup_addr != '0) &&
             (addr_q[idx] == lookup_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[idx];
         end
      end
   end
`endif

endmodule
